// File: rtl/image_mem_writer.sv
// rtl/image_mem_writer.sv - loads a width/height-prefixed byte stream into RAM
// A 4-byte big-endian header (width, height) is written to fixed RAM slots, then width*height pixel bytes follow.

module image_mem_writer #(
   parameter logic [17:0] BASE_ADDRESS = 18'h10,
   parameter int unsigned MAX_PIXELS   = 262128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [17:0] wraddress,
   output logic [7:0]  data,
   output logic        wren,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] img_width,
   output logic [15:0] img_height
);

   typedef enum logic [2:0] {
      IDLE,
      HDR_WH,
      HDR_WL,
      HDR_HH,
      HDR_HL,
      CHECK,
      PIXELS,
      ERROR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [17:0] pix_cnt;
   logic [17:0] last_idx;
   logic [31:0] product;
   logic        xfer;
   logic        size_bad;
   logic        last_pix;

   assign product  = 32'(img_width) * 32'(img_height);
   assign size_bad = (product == 32'd0) || (product > MAX_PIXELS);
   assign xfer     = in_valid && in_ready;
   assign last_pix = (pix_cnt == last_idx);
   assign busy     = (state != IDLE) && (state != ERROR);
   assign error    = (state == ERROR);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE, ERROR: begin
            if (start) state_nxt = HDR_WH;
         end
         HDR_WH: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = HDR_WL;
         end
         HDR_WL: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = HDR_HH;
         end
         HDR_HH: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = HDR_HL;
         end
         HDR_HL: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = CHECK;
         end
         CHECK: begin
            state_nxt = size_bad ? ERROR : PIXELS;
         end
         PIXELS: begin
            in_ready = 1'b1;
            if (in_valid && last_pix) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write port is fully registered: each transfer shows up on the RAM bus one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wren       <= 1'b0;
         done       <= 1'b0;
         wraddress  <= 18'h0;
         data       <= 8'h0;
         img_width  <= 16'h0;
         img_height <= 16'h0;
         pix_cnt    <= 18'h0;
         last_idx   <= 18'h0;
      end else begin
         state <= state_nxt;
         wren  <= 1'b0;
         done  <= 1'b0;
         if (state == CHECK) begin
            pix_cnt  <= 18'h0;
            last_idx <= product[17:0] - 18'd1;
         end
         if (xfer) begin
            wren <= 1'b1;
            data <= in_data;
            case (state)
               HDR_WH: begin
                  wraddress        <= 18'h0;
                  img_width[15:8]  <= in_data;
               end
               HDR_WL: begin
                  wraddress        <= 18'h1;
                  img_width[7:0]   <= in_data;
               end
               HDR_HH: begin
                  wraddress        <= 18'h4;
                  img_height[15:8] <= in_data;
               end
               HDR_HL: begin
                  wraddress        <= 18'h5;
                  img_height[7:0]  <= in_data;
               end
               PIXELS: begin
                  wraddress <= BASE_ADDRESS + pix_cnt;
                  pix_cnt   <= pix_cnt + 18'd1;
                  done      <= last_pix;
               end
               default: wren <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_image_mem_writer.sv
// tb/tb_image_mem_writer.sv - randomized frame loads against a write-list reference model
// Each frame's expected RAM writes are derived from the header rules and compared to the observed bus.

module tb_image_mem_writer;

   localparam logic [17:0] BASE = 18'h10;
   localparam int unsigned MAXP = 262128;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [17:0] wraddress;
   logic [7:0]  data;
   logic        wren;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] img_width;
   logic [15:0] img_height;

   image_mem_writer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .wraddress  (wraddress),
      .data       (data),
      .wren       (wren),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .img_width  (img_width),
      .img_height (img_height)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [25:0] wr_q[$];
   int          done_cnt = 0;
   logic [17:0] done_addr = 18'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wren === 1'b1) wr_q.push_back({wraddress, data});
      if (done === 1'b1) begin
         done_cnt++;
         done_addr = (wren === 1'b1) ? wraddress : 18'h3ffff;
      end
   end

   // mode: 0 continuous valid, 1 valid toggling, 2 random valid
   task automatic run_frame(input logic [15:0] w, input logic [15:0] h, input int mode,
                            input bit fixed, input int start_at, input int rst_at);
      logic [7:0]  bytes[$];
      logic [25:0] exp[$];
      logic [31:0] prod;
      logic [7:0]  b;
      bit          ok, tgl, take, did_rst;
      int          npix, total, idx, cyc, limit, bad, n;

      prod    = 32'(w) * 32'(h);
      ok      = (prod != 0) && (prod <= MAXP);
      npix    = ok ? int'(prod) : 0;
      did_rst = (rst_at >= 0) && (rst_at < npix);
      if (did_rst) npix = rst_at;

      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
      bytes.push_back(h[15:8]);
      bytes.push_back(h[7:0]);
      exp.push_back({18'h0, w[15:8]});
      exp.push_back({18'h1, w[7:0]});
      exp.push_back({18'h4, h[15:8]});
      exp.push_back({18'h5, h[7:0]});
      for (int i = 0; i < npix; i++) begin
         b = fixed ? 8'(8'hAA + 8'h11 * i) : 8'($urandom);
         bytes.push_back(b);
         exp.push_back({BASE + 18'(i), b});
      end
      total = 4 + npix;

      wr_q.delete();
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("error_after_start", error, 0);
      check("ready_in_header", in_ready, 1);

      idx   = 0;
      cyc   = 0;
      tgl   = 1'b1;
      limit = 4 * total + 50;
      while (idx < total && cyc < limit) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       begin in_valid = tgl; tgl = !tgl; end
            default: in_valid = ($urandom_range(99) < 60);
         endcase
         in_data = in_valid ? bytes[idx] : 8'($urandom);
         start   = (start_at >= 0) && (idx == 4 + start_at);
         take    = in_valid && in_ready;
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (take) begin
            idx++;
            if (idx == 4) begin
               check("check_cycle_ready", in_ready, 0);
               check("check_cycle_busy", busy, 1);
            end
         end
      end
      check("stream_progress", idx, total);

      if (did_rst) begin
         in_valid = 1'b1;
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("rst_wren", wren, 0);
         check("rst_busy", busy, 0);
         check("rst_ready", in_ready, 0);
         check("rst_width", img_width, 0);
         repeat (3) @(negedge clk);
         in_valid = 1'b0;
         check("rst_done_cnt", done_cnt, 0);
      end else if (!ok) begin
         in_valid = 1'b1;
         @(negedge clk);
         check("err_flag", error, 1);
         check("err_ready", in_ready, 0);
         check("err_busy", busy, 0);
         repeat (3) @(negedge clk);
         check("err_hold", error, 1);
         check("err_ready_hold", in_ready, 0);
         in_valid = 1'b0;
         check("err_done_cnt", done_cnt, 0);
         check("err_width", img_width, w);
         check("err_height", img_height, h);
      end else begin
         in_valid = 1'b0;
         @(negedge clk);
         check("done_cnt", done_cnt, 1);
         check("done_with_last_write", done_addr, BASE + 18'(prod - 32'd1));
         check("end_busy", busy, 0);
         check("end_ready", in_ready, 0);
         check("end_error", error, 0);
         check("width", img_width, w);
         check("height", img_height, h);
      end

      check("write_count", wr_q.size(), exp.size());
      n   = (wr_q.size() < exp.size()) ? wr_q.size() : exp.size();
      bad = -1;
      for (int i = 0; i < n; i++) begin
         if (wr_q[i] !== exp[i]) begin
            bad = i;
            break;
         end
      end
      if (bad < 0) bad = n - 1;
      if (n > 0) check("write_seq", wr_q[bad], exp[bad]);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h0;
      repeat (2) @(negedge clk);
      check("reset_ready", in_ready, 0);
      check("reset_wren", wren, 0);
      check("reset_done", done, 0);
      check("reset_busy", busy, 0);
      check("reset_error", error, 0);
      check("reset_wraddress", wraddress, 0);
      check("reset_data", data, 0);
      check("reset_width", img_width, 0);
      check("reset_height", img_height, 0);
      rst = 1'b0;

      run_frame(16'd2, 16'd2, 0, 1'b1, -1, -1);
      run_frame(16'd2, 16'd2, 1, 1'b1, -1, -1);
      run_frame(16'd0, 16'd5, 2, 1'b0, -1, -1);
      run_frame(16'h0200, 16'h0200, 0, 1'b0, -1, -1);
      run_frame(16'd5, 16'd0, 1, 1'b0, -1, -1);
      for (int k = 0; k < 4; k++)
         run_frame(16'($urandom_range(6, 1)), 16'($urandom_range(6, 1)), 2, 1'b0, -1, -1);
      run_frame(16'd3, 16'd3, 2, 1'b0, 4, -1);
      run_frame(16'd4, 16'd4, 0, 1'b0, -1, 3);
      run_frame(16'd2, 16'd2, 2, 1'b0, -1, -1);
      run_frame(16'h0100, 16'h00FF, 0, 1'b0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/image_mem_writer.md
IMAGE_MEM_WRITER -- requirements
Module: image_mem_writer

Interface
REQ-001 The module SHALL have parameter BASE_ADDRESS, default 18'h10, the RAM address of pixel 0.
REQ-002 The module SHALL have parameter MAX_PIXELS, default 262128, the largest accepted width*height (2^18 - 16).
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin loading a frame.
REQ-006 in_data  input  8  stream byte.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block accepts a byte this cycle.
REQ-009 wraddress  output  18  RAM write address.
REQ-010 data  output  8  RAM write data.
REQ-011 wren  output  1  RAM write enable, one cycle per write.
REQ-012 busy  output  1  frame load in progress.
REQ-013 done  output  1  one-cycle pulse, frame fully written.
REQ-014 error  output  1  header rejected; held until next accepted start.
REQ-015 img_width  output  16  latched width.
REQ-016 img_height  output  16  latched height.

Function
REQ-017 A transfer SHALL occur only on a cycle where in_valid and in_ready are both 1.
REQ-018 States SHALL be IDLE, HDR_WH, HDR_WL, HDR_HH, HDR_HL, CHECK, PIXELS, ERROR.
REQ-019 IDLE: start=1 SHALL go to HDR_WH, set busy=1, clear error; otherwise remain.
REQ-020 Header byte order SHALL be width high, width low, height high, height low, each advancing one state per transfer; HDR_HL goes to CHECK.
REQ-021 Header bytes SHALL be written to RAM addresses 18'h0, 18'h1, 18'h4, 18'h5 respectively; addresses 2, 3, 6..15 SHALL NOT be written.
REQ-022 Every write SHALL appear on wraddress/data/wren in the cycle after its transfer (registered outputs, latency 1).
REQ-023 CHECK SHALL last exactly one cycle with in_ready=0, computing a 32-bit product img_width*img_height.
REQ-024 Product 0 or product > MAX_PIXELS SHALL go to ERROR; otherwise go to PIXELS with pixel counter 0.
REQ-025 PIXELS: transfer n (0-based) SHALL write in_data to BASE_ADDRESS + n; 18-bit address, counter never wraps within a frame.
REQ-026 The last pixel transfer (n = product-1) SHALL go to IDLE; done SHALL assert in the same cycle as the last pixel's wren, with busy=0 from that cycle.
REQ-027 ERROR: error=1, busy=0, in_ready=0, wren=0; start=1 SHALL behave as in IDLE.
REQ-028 in_ready SHALL be 1 exactly in HDR_WH, HDR_WL, HDR_HH, HDR_HL, PIXELS.
REQ-029 start SHALL be ignored in all states other than IDLE and ERROR.
REQ-030 Cycles with in_valid=0 SHALL produce no write and no state change.
REQ-031 img_width/img_height SHALL hold their last header values until overwritten by the next frame's header.

Reset
REQ-032 rst=1 SHALL, at the next rising edge, force IDLE, in_ready=0, wren=0, done=0, busy=0, error=0, wraddress=0, data=0, img_width=0, img_height=0, pixel counter=0, regardless of state.
REQ-033 Reset mid-frame SHALL abandon the frame; no write SHALL occur after the reset edge.

Verification
REQ-034 start, stream 00 02 00 02 AA BB CC DD continuous -> writes (0,00)(1,02)(4,00)(5,02)(0x10,AA)(0x11,BB)(0x12,CC)(0x13,DD); done=1 with the 0x13 write; img_width=img_height=2.
REQ-035 Same 2x2 stream with in_valid toggling 1/0 each cycle -> identical write sequence, wren only on cycles after transfers, one CHECK cycle with in_ready=0.
REQ-036 Header 00 00 00 05 -> error=1 after CHECK, no writes at >= 0x10, in_ready=0 until next start.
REQ-037 Header 02 00 02 00 (262144 pixels) -> error=1; header 01 00 00 FF (65280 pixels) -> PIXELS entered, last write at 0x10+65279.
REQ-038 rst=1 after 3 pixels of a 4x4 frame -> next cycle wren=0, busy=0, in_ready=0; subsequent start reloads from address 0.
REQ-039 start pulsed during PIXELS -> ignored; frame completes normally with one done pulse.
